// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: instruction size limits, advance-length width
// and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int WORD_WIDTH_DEF  = 32;
    localparam int MAX_INSTR_BYTES = 1 + WORD_WIDTH_DEF / 8;
    localparam int ADV_LEN_W       = 4;

    typedef enum logic {
        S_REDIRECT = 1'b0,
        S_RUN      = 1'b1
    } fetch_state_e;

    function automatic int max_instr_bytes(input int word_width);
        return 1 + word_width / 8;
    endfunction

    // Index width that never collapses to zero bits for size-1 structures.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Circular byte prefetch queue: word-wide push with leading-byte drop,
// variable-length pop and a zero-masked instruction window at the head.
module instruction_fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int FETCH_BYTES  = 4,
    parameter int BUFFER_BYTES = 8,
    parameter int WIN_BYTES    = 5
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic                              push,
    input  logic [FETCH_BYTES*8-1:0]          push_data,
    input  logic [idx_w(FETCH_BYTES)-1:0]     drop,
    input  logic                              pop,
    input  logic [ADV_LEN_W-1:0]              pop_len,
    output logic [$clog2(BUFFER_BYTES+1)-1:0] count,
    output logic [WIN_BYTES*8-1:0]            window
);
    localparam int PW = idx_w(BUFFER_BYTES);
    localparam int CW = $clog2(BUFFER_BYTES + 1);

    logic [7:0]    mem [BUFFER_BYTES];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] pop_n;
    logic [CW-1:0] push_n;
    logic          wr_en;

    // A full queue makes tail wrap onto head; no push is issued then.
    assign tail   = head + PW'(count);
    assign wr_en  = push && reset_n && !flush;
    assign pop_n  = pop  ? CW'(pop_len) : '0;
    assign push_n = push ? CW'(FETCH_BYTES) - CW'(drop) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            head  <= '0;
            count <= '0;
        end else begin
            if (pop) head <= head + PW'(pop_len);
            count <= count - pop_n + push_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_BYTES; i++) begin
            if (wr_en && i >= int'(drop))
                mem[tail + PW'(i) - PW'(drop)] <= push_data[8*i +: 8];
        end
    end

    always_comb begin
        window = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            if (k < int'(count)) window[8*k +: 8] = mem[head + PW'(k)];
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues aligned program-memory reads into a byte
// prefetch queue and exposes an opcode+immediate window at the current pc.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int WORD_WIDTH         = 32,
    parameter int PROGRAM_ADDR_WIDTH = 16,
    parameter int FETCH_BYTES        = 4,
    parameter int BUFFER_BYTES       = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    output logic                                progmem_req,
    output logic [PROGRAM_ADDR_WIDTH-1:0]       progmem_addr,
    input  logic [FETCH_BYTES*8-1:0]            progmem_data,
    input  logic                                redirect,
    input  logic [PROGRAM_ADDR_WIDTH-1:0]       redirect_pc,
    input  logic                                advance,
    input  logic [ADV_LEN_W-1:0]                advance_len,
    output logic [PROGRAM_ADDR_WIDTH-1:0]       pc,
    output logic [(1+WORD_WIDTH/8)*8-1:0]       window,
    output logic [$clog2(BUFFER_BYTES+1)-1:0]   bytes_avail
);
    localparam int WIN_BYTES = max_instr_bytes(WORD_WIDTH);
    localparam int DW        = idx_w(FETCH_BYTES);
    localparam logic [PROGRAM_ADDR_WIDTH-1:0] OFS_MASK = PROGRAM_ADDR_WIDTH'(FETCH_BYTES - 1);

    fetch_state_e                  state;
    logic                          inflight;
    logic [DW-1:0]                 drop_count;
    logic [PROGRAM_ADDR_WIDTH-1:0] fetch_addr;
    logic                          adv_ok;

    assign adv_ok = advance && !redirect && (advance_len != '0)
                    && (int'(advance_len) <= int'(bytes_avail));

    // Space check counts the in-flight word but deliberately not this cycle's advance.
    assign progmem_req  = (state == S_RUN)
                          && (int'(bytes_avail) + (inflight ? FETCH_BYTES : 0) + FETCH_BYTES
                              <= BUFFER_BYTES);
    assign progmem_addr = fetch_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_REDIRECT;
            pc         <= '0;
            fetch_addr <= '0;
            drop_count <= '0;
            inflight   <= 1'b0;
        end else if (redirect) begin
            state      <= S_REDIRECT;
            pc         <= redirect_pc;
            fetch_addr <= redirect_pc & ~OFS_MASK;
            drop_count <= DW'(redirect_pc & OFS_MASK);
            inflight   <= 1'b0;
        end else begin
            case (state)
                S_REDIRECT: state <= S_RUN;
                default:    state <= S_RUN;
            endcase
            inflight <= progmem_req;
            if (progmem_req) fetch_addr <= fetch_addr + PROGRAM_ADDR_WIDTH'(FETCH_BYTES);
            if (inflight)    drop_count <= '0;
            if (adv_ok)      pc <= pc + PROGRAM_ADDR_WIDTH'(advance_len);
        end
    end

    instruction_fetch_queue #(
        .FETCH_BYTES  (FETCH_BYTES),
        .BUFFER_BYTES (BUFFER_BYTES),
        .WIN_BYTES    (WIN_BYTES)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect),
        .push      (inflight && !redirect),
        .push_data (progmem_data),
        .drop      (drop_count),
        .pop       (adv_ok),
        .pop_len   (advance_len),
        .count     (bytes_avail),
        .window    (window)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: byte[a]=a[7:0] memory model, request-address and
// pc scoreboards, a vector table for advance rules, and redirect/reset sequences.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        progmem_req;
    logic [15:0] progmem_addr;
    logic [31:0] progmem_data = '0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        advance;
    logic [3:0]  advance_len;
    logic [15:0] pc;
    logic [39:0] window;
    logic [3:0]  bytes_avail;

    int          tests = 0;
    int          fails = 0;
    logic        mon_en;
    logic [15:0] exp_addr [$];
    logic [15:0] exp_pc [$];
    logic [15:0] ea;
    logic [15:0] pm;

    typedef struct {
        logic        adv;
        logic [3:0]  len;
        logic [15:0] pc;
        int          avail;
    } vec_t;
    vec_t tbl [9];

    instruction_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .progmem_req  (progmem_req),
        .progmem_addr (progmem_addr),
        .progmem_data (progmem_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .advance      (advance),
        .advance_len  (advance_len),
        .pc           (pc),
        .window       (window),
        .bytes_avail  (bytes_avail)
    );

    always #5 clk = ~clk;

    // One-cycle-latency program memory.
    always @(posedge clk) begin
        if (progmem_req)
            for (int b = 0; b < 4; b++) progmem_data[8*b +: 8] <= 8'(progmem_addr + 16'(b));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] win_model(input logic [15:0] p, input int avail);
        logic [39:0] w = '0;
        for (int k = 0; k < MAX_INSTR_BYTES; k++)
            if (k < avail) w[8*k +: 8] = 8'(p + 16'(k));
        return w;
    endfunction

    // Request scoreboard: every issued request must match the next expected address.
    always @(negedge clk) begin
        #1;
        if (mon_en && progmem_req) begin
            tests++;
            if (exp_addr.size() == 0) begin
                fails++;
                $display("FAIL req_unexpected: got addr %0h expected none", progmem_addr);
            end else begin
                ea = exp_addr.pop_front();
                if (progmem_addr !== ea) begin
                    fails++;
                    $display("FAIL req_addr: got %0h expected %0h", progmem_addr, ea);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 4'd4, 16'd68, 4};
        tbl[1] = '{1'b1, 4'd5, 16'd68, 4};  // longer than available: ignored
        tbl[2] = '{1'b1, 4'd0, 16'd68, 8};  // zero length: ignored, refill lands
        tbl[3] = '{1'b0, 4'd3, 16'd68, 8};
        tbl[4] = '{1'b1, 4'd5, 16'd73, 3};
        tbl[5] = '{1'b1, 4'd3, 16'd76, 0};  // exactly bytes_avail: accepted
        tbl[6] = '{1'b1, 4'd1, 16'd76, 4};  // empty queue: ignored
        tbl[7] = '{1'b1, 4'd2, 16'd78, 6};
        tbl[8] = '{1'b0, 4'd0, 16'd78, 6};

        reset_n = 0; redirect = 0; redirect_pc = '0; advance = 0; advance_len = '0; mon_en = 0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_avail", bytes_avail, 0);
        chk("rst_window", window, 0);
        chk("rst_req", progmem_req, 0);

        // Initial fill
        reset_n = 1; mon_en = 1;
        exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0004);
        repeat (4) @(negedge clk);
        chk("fill_avail", bytes_avail, 8);
        chk("fill_pc", pc, 0);
        chk("fill_window", window, 40'h04_03_02_01_00);
        chk("fill_req_idle", progmem_req, 0);
        chk("fill_reqs_left", exp_addr.size(), 0);

        // Streaming one byte per cycle
        for (int a = 8; a <= 68; a += 4) exp_addr.push_back(16'(a));
        pm = '0;
        for (int i = 0; i <= 64; i++) begin
            if (i > 0) begin
                chk("stream_pc", pc, exp_pc.pop_front());
                chk("stream_byte0", window[7:0], pm[7:0]);
                chk("stream_avail_nz", bytes_avail != 0, 1);
            end
            if (i < 64) begin
                advance = 1; advance_len = 1;
                pm = pm + 16'd1;
                exp_pc.push_back(pm);
                @(negedge clk);
            end else begin
                advance = 0;
            end
        end
        repeat (3) @(negedge clk);
        chk("settle_pc", pc, 64);
        chk("settle_avail", bytes_avail, 8);
        chk("stream_reqs_left", exp_addr.size(), 0);

        // Advance rules
        exp_addr.push_back(16'd72); exp_addr.push_back(16'd76); exp_addr.push_back(16'd80);
        for (int i = 0; i < 9; i++) begin
            advance = tbl[i].adv; advance_len = tbl[i].len;
            @(negedge clk);
            chk("tbl_pc", pc, tbl[i].pc);
            chk("tbl_avail", bytes_avail, 64'(tbl[i].avail));
            chk("tbl_window", window, win_model(tbl[i].pc, tbl[i].avail));
        end
        advance = 0;
        chk("tbl_reqs_left", exp_addr.size(), 0);

        // Unaligned redirect
        redirect = 1; redirect_pc = 16'h0103;
        exp_addr.push_back(16'h0100); exp_addr.push_back(16'h0104);
        @(negedge clk);
        chk("redir_pc", pc, 16'h0103);
        chk("redir_avail", bytes_avail, 0);
        chk("redir_bubble_req", progmem_req, 0);
        redirect = 0;
        repeat (3) @(negedge clk);
        chk("redir_avail1", bytes_avail, 1);
        chk("redir_window1", window, 40'h03);
        @(negedge clk);
        chk("redir_avail5", bytes_avail, 5);
        chk("redir_window5", window, 40'h07_06_05_04_03);
        chk("redir_reqs_left", exp_addr.size(), 0);

        // Redirect colliding with advance and a live response
        advance = 1; advance_len = 4;
        @(negedge clk);
        chk("pre_coll_pc", pc, 16'h0107);
        exp_addr.push_back(16'h0108);
        advance = 0;
        @(negedge clk);
        chk("pre_coll_avail", bytes_avail, 1);
        redirect = 1; redirect_pc = 16'h0200; advance = 1; advance_len = 1;
        exp_addr.push_back(16'h0200); exp_addr.push_back(16'h0204);
        @(negedge clk);
        chk("coll_pc", pc, 16'h0200);
        chk("coll_avail", bytes_avail, 0);
        chk("coll_window", window, 0);
        redirect = 0; advance = 0;
        repeat (4) @(negedge clk);
        chk("coll_refill_avail", bytes_avail, 8);
        chk("coll_refill_window", window, win_model(16'h0200, 8));

        // Redirect across the address-space wrap
        redirect = 1; redirect_pc = 16'hFFFE;
        exp_addr.push_back(16'hFFFC); exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0004);
        @(negedge clk);
        chk("wrap_pc", pc, 16'hFFFE);
        redirect = 0;
        repeat (3) @(negedge clk);
        chk("wrap_avail2", bytes_avail, 2);
        @(negedge clk);
        chk("wrap_avail6", bytes_avail, 6);
        chk("wrap_window", window, 40'h02_01_00_FF_FE);
        advance = 1; advance_len = 5;
        @(negedge clk);
        chk("wrap_adv_pc", pc, 16'h0003);
        chk("wrap_adv_window", window, win_model(16'h0003, 1));

        // One-cycle reset while a request's response is still to come
        advance = 0; reset_n = 0;
        @(negedge clk);
        chk("mrst_pc", pc, 0);
        chk("mrst_avail", bytes_avail, 0);
        chk("mrst_window", window, 0);
        chk("mrst_req", progmem_req, 0);
        reset_n = 1;
        exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0004);
        @(negedge clk);
        chk("mrst_discard_avail", bytes_avail, 0);
        chk("mrst_first_req", progmem_req, 1);
        repeat (3) @(negedge clk);
        chk("mrst_refill_avail", bytes_avail, 8);
        chk("mrst_refill_window", window, 40'h04_03_02_01_00);
        chk("mrst_reqs_left", exp_addr.size(), 0);

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
